// File: rtl/pipeline_retire_tracker.sv
// Shadows the IF/ID..MEM/WB pipeline registers with sequence tags and queues
// each retiring instruction as {tag, pc, instr} in a small FWFT FIFO.
module pipeline_retire_tracker #(
  parameter int unsigned TAG_W      = 7,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [15:0]      if_pc,
  input  logic [15:0]      if_instr,
  input  logic             stall,
  input  logic             flush,
  output logic             wb_valid,
  output logic [TAG_W-1:0] wb_tag,
  output logic             ret_valid,
  output logic [TAG_W-1:0] ret_tag,
  output logic [15:0]      ret_pc,
  output logic [15:0]      ret_instr,
  input  logic             ret_ready,
  output logic             overflow,
  output logic [15:0]      retired_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [15:0]      pc;
    logic [15:0]      instr;
  } slot_t;

  slot_t            id_q, id_d, ex_q, ex_d, mem_q, mem_d;
  logic             wb_valid_q;
  logic [TAG_W-1:0] wb_tag_q;
  logic [TAG_W-1:0] next_tag_q, next_tag_d;

  logic [TAG_W+31:0] buf_q [FIFO_DEPTH];
  logic [PTR_W:0]    wr_q, rd_q;
  logic              overflow_q;
  logic [15:0]       retired_q;
  logic              empty, full, push, pop, push_ok;
  logic [TAG_W+31:0] head;

  always_comb begin
    id_d       = id_q;
    ex_d       = '0;
    next_tag_d = next_tag_q;
    if (!stall) begin
      id_d.valid = if_valid & ~flush;
      id_d.tag   = next_tag_q;
      id_d.pc    = if_pc;
      id_d.instr = if_instr;
      ex_d       = id_q;
      if (if_valid && !flush) next_tag_d = next_tag_q + 1'b1;
    end
    mem_d = ex_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q       <= '0;
      ex_q       <= '0;
      mem_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_tag_q   <= '0;
      next_tag_q <= '0;
    end else begin
      id_q       <= id_d;
      ex_q       <= ex_d;
      mem_q      <= mem_d;
      wb_valid_q <= mem_q.valid;
      wb_tag_q   <= mem_q.tag;
      next_tag_q <= next_tag_d;
    end
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[PTR_W] != rd_q[PTR_W]) && (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
  assign push    = mem_q.valid;
  assign pop     = ~empty & ret_ready;
  assign push_ok = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (push_ok) buf_q[wr_q[PTR_W-1:0]] <= {mem_q.tag, mem_q.pc, mem_q.instr};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q       <= '0;
      rd_q       <= '0;
      overflow_q <= 1'b0;
      retired_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_q      <= wr_q + 1'b1;
        retired_q <= retired_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      if (push && full && !pop) overflow_q <= 1'b1;
    end
  end

  assign head          = buf_q[rd_q[PTR_W-1:0]];
  assign ret_valid     = ~empty;
  assign ret_tag       = ret_valid ? head[TAG_W+31:32] : '0;
  assign ret_pc        = ret_valid ? head[31:16] : '0;
  assign ret_instr     = ret_valid ? head[15:0] : '0;
  assign wb_valid      = wb_valid_q;
  assign wb_tag        = wb_tag_q;
  assign overflow      = overflow_q;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_pipeline_retire_tracker.sv
// Directed bench for pipeline_retire_tracker; a second instance with a 3-bit
// tag checks tag wrap-around.
module tb_pipeline_retire_tracker;

  logic        clk, rst, if_valid, stall, flush, ret_ready;
  logic [15:0] if_pc, if_instr;
  logic        wb_valid, ret_valid, overflow;
  logic [6:0]  wb_tag, ret_tag;
  logic [15:0] ret_pc, ret_instr, retired_count;
  logic        wb_valid3, ret_valid3, overflow3;
  logic [2:0]  wb_tag3, ret_tag3;
  logic [15:0] ret_pc3, ret_instr3, retired_count3;

  int total = 0;
  int bad   = 0;

  pipeline_retire_tracker #(.TAG_W(7), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .stall(stall), .flush(flush), .wb_valid(wb_valid), .wb_tag(wb_tag),
    .ret_valid(ret_valid), .ret_tag(ret_tag), .ret_pc(ret_pc), .ret_instr(ret_instr),
    .ret_ready(ret_ready), .overflow(overflow), .retired_count(retired_count)
  );

  pipeline_retire_tracker #(.TAG_W(3), .FIFO_DEPTH(4)) dut3 (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .stall(stall), .flush(flush), .wb_valid(wb_valid3), .wb_tag(wb_tag3),
    .ret_valid(ret_valid3), .ret_tag(ret_tag3), .ret_pc(ret_pc3), .ret_instr(ret_instr3),
    .ret_ready(ret_ready), .overflow(overflow3), .retired_count(retired_count3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic v, input logic [15:0] pc);
    if_valid = v;
    if_pc    = pc;
    if_instr = pc ^ 16'hA5A5;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fetch(1'b0, 16'h0);
    stall = 1'b0; flush = 1'b0; ret_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fetch(1'b0, 16'h0);
    stall = 1'b0; flush = 1'b0; ret_ready = 1'b0;
    tick();
    total++;
    if ({wb_valid, wb_tag, ret_valid, ret_tag, ret_pc, ret_instr, overflow, retired_count} !== '0) begin
      bad++;
      $display("FAIL reset: wbv=%b wbt=%0d rv=%b rt=%0d pc=%h in=%h ovf=%b cnt=%0d, all zero required",
               wb_valid, wb_tag, ret_valid, ret_tag, ret_pc, ret_instr, overflow, retired_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    bit ev [7] = '{0, 0, 0, 1, 1, 1, 0};
    do_reset();
    ret_ready = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      fetch(e <= 3, 16'(2 * (e - 1)));
      tick();
      total++;
      if (ret_valid !== ev[e-1]) begin
        bad++; $display("FAIL basic_valid edge %0d: got %b want %b", e, ret_valid, ev[e-1]);
      end
      if (ev[e-1]) begin
        total++;
        if (ret_tag !== 7'(e - 4) || ret_pc !== 16'(2 * (e - 4)) ||
            ret_instr !== (16'(2 * (e - 4)) ^ 16'hA5A5) || wb_valid !== 1'b1 || wb_tag !== 7'(e - 4)) begin
          bad++;
          $display("FAIL basic_rec edge %0d: tag=%0d pc=%h in=%h wbv=%b wbt=%0d want tag=%0d pc=%h",
                   e, ret_tag, ret_pc, ret_instr, wb_valid, wb_tag, e - 4, 2 * (e - 4));
        end
      end
    end
    total++;
    if (retired_count !== 16'd3) begin
      bad++; $display("FAIL basic_count: got %0d want 3", retired_count);
    end
  endtask

  task automatic test_stall();
    bit ev [8] = '{0, 0, 0, 1, 0, 1, 1, 0};
    int et [8] = '{0, 0, 0, 0, 0, 1, 2, 0};
    do_reset();
    ret_ready = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      case (e)
        1: fetch(1'b1, 16'h0000);
        2: fetch(1'b1, 16'h0002);
        3, 4: fetch(1'b1, 16'h0004);
        default: fetch(1'b0, 16'h0000);
      endcase
      stall = (e == 3);
      tick();
      total++;
      if (ret_valid !== ev[e-1] || (ev[e-1] && (ret_tag !== 7'(et[e-1]) || ret_pc !== 16'(2 * et[e-1])))) begin
        bad++;
        $display("FAIL stall edge %0d: rv=%b tag=%0d pc=%h want rv=%b tag=%0d", e, ret_valid, ret_tag, ret_pc,
                 ev[e-1], et[e-1]);
      end
    end
    stall = 1'b0;
  endtask

  task automatic test_flush();
    bit          ev [7] = '{0, 0, 0, 1, 0, 1, 0};
    logic [15:0] ep [7] = '{16'h0, 16'h0, 16'h0, 16'h0000, 16'h0, 16'h0012, 16'h0};
    int          et [7] = '{0, 0, 0, 0, 0, 1, 0};
    do_reset();
    ret_ready = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      case (e)
        1: fetch(1'b1, 16'h0000);
        2: fetch(1'b1, 16'h0010);
        3: fetch(1'b1, 16'h0012);
        default: fetch(1'b0, 16'h0000);
      endcase
      flush = (e == 2);
      tick();
      total++;
      if (ret_valid !== ev[e-1] || (ev[e-1] && (ret_tag !== 7'(et[e-1]) || ret_pc !== ep[e-1]))) begin
        bad++;
        $display("FAIL flush edge %0d: rv=%b tag=%0d pc=%h want rv=%b tag=%0d pc=%h", e, ret_valid, ret_tag,
                 ret_pc, ev[e-1], et[e-1], ep[e-1]);
      end
    end
    flush = 1'b0;
    total++;
    if (retired_count !== 16'd2) begin
      bad++; $display("FAIL flush_count: got %0d want 2", retired_count);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int e = 1; e <= 9; e++) begin
      fetch(e <= 6, 16'(2 * (e - 1)));
      tick();
      total++;
      if (overflow !== (e >= 8)) begin
        bad++; $display("FAIL ovf_flag edge %0d: got %b want %b", e, overflow, e >= 8);
      end
    end
    total++;
    if (retired_count !== 16'd4) begin
      bad++; $display("FAIL ovf_count: got %0d want 4", retired_count);
    end
    ret_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (ret_valid !== 1'b1 || ret_tag !== 7'(k) || ret_pc !== 16'(2 * k)) begin
        bad++; $display("FAIL ovf_drain %0d: rv=%b tag=%0d pc=%h want tag=%0d", k, ret_valid, ret_tag, ret_pc, k);
      end
      tick();
    end
    total++;
    if (ret_valid !== 1'b0 || overflow !== 1'b1) begin
      bad++; $display("FAIL ovf_empty: rv=%b ovf=%b want rv=0 ovf=1", ret_valid, overflow);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int e = 1; e <= 12; e++) begin
      fetch(e <= 5, 16'(2 * (e - 1)));
      ret_ready = (e >= 8);
      tick();
      if (e == 7) begin
        total++;
        if (ret_valid !== 1'b1 || ret_tag !== 7'd0 || retired_count !== 16'd4 || overflow !== 1'b0) begin
          bad++; $display("FAIL b2b_full: rv=%b tag=%0d cnt=%0d ovf=%b want 1/0/4/0", ret_valid, ret_tag,
                          retired_count, overflow);
        end
      end
      if (e >= 8 && e <= 11) begin
        total++;
        if (ret_valid !== 1'b1 || ret_tag !== 7'(e - 7) || retired_count !== 16'd5 || overflow !== 1'b0) begin
          bad++; $display("FAIL b2b edge %0d: rv=%b tag=%0d cnt=%0d ovf=%b want tag=%0d cnt=5 ovf=0", e,
                          ret_valid, ret_tag, retired_count, overflow, e - 7);
        end
      end
      if (e == 12) begin
        total++;
        if (ret_valid !== 1'b0) begin
          bad++; $display("FAIL b2b_empty: rv=%b want 0", ret_valid);
        end
      end
    end
  endtask

  task automatic test_tag_wrap();
    do_reset();
    ret_ready = 1'b1;
    for (int e = 1; e <= 13; e++) begin
      fetch(e <= 9, 16'(2 * (e - 1)));
      tick();
      if (e >= 4 && e <= 12) begin
        total++;
        if (ret_valid3 !== 1'b1 || ret_tag3 !== 3'((e - 4) % 8) || wb_tag3 !== 3'((e - 4) % 8) ||
            ret_tag !== 7'(e - 4)) begin
          bad++; $display("FAIL wrap edge %0d: rv3=%b tag3=%0d wbt3=%0d tag7=%0d want tag3=%0d tag7=%0d", e,
                          ret_valid3, ret_tag3, wb_tag3, ret_tag, (e - 4) % 8, e - 4);
        end
      end
    end
    total++;
    if (ret_valid3 !== 1'b0 || retired_count3 !== 16'd9) begin
      bad++; $display("FAIL wrap_end: rv3=%b cnt3=%0d want 0/9", ret_valid3, retired_count3);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int e = 1; e <= 9; e++) begin
      fetch(e <= 6, 16'(2 * (e - 1)));
      tick();
    end
    total++;
    if (ret_valid !== 1'b1 || overflow !== 1'b1) begin
      bad++; $display("FAIL rstmid_pre: rv=%b ovf=%b want 1/1", ret_valid, overflow);
    end
    rst = 1'b1;
    #1;
    total++;
    if (ret_valid !== 1'b0 || overflow !== 1'b0 || retired_count !== 16'd0 || wb_valid !== 1'b0 || ret_tag !== 7'd0) begin
      bad++; $display("FAIL rstmid_async: rv=%b ovf=%b cnt=%0d wbv=%b tag=%0d want all 0", ret_valid, overflow,
                      retired_count, wb_valid, ret_tag);
    end
    #2;
    rst = 1'b0;
    ret_ready = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      fetch(e == 1, 16'h0040);
      tick();
      total++;
      if (ret_valid !== (e == 4) || (e == 4 && (ret_tag !== 7'd0 || ret_pc !== 16'h0040))) begin
        bad++; $display("FAIL rstmid_restart edge %0d: rv=%b tag=%0d pc=%h want rv=%b tag=0 pc=0040", e,
                        ret_valid, ret_tag, ret_pc, e == 4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_flush();
    test_overflow();
    test_back_to_back();
    test_tag_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
